alu_issue_ctrl: RTL and testbench

- Two-requester scheduler that shares one set of ALU execution units (arithmetic, logic, compare, shift) between two command sources.
- Accepts commands over valid/ready and arbitrates round-robin.
- Sequences the selected unit through enable, op code and operands, waits out the unit's one-cycle registered latency, and returns a tagged result on a single response channel.
- Sits between the command front-end and the ALU unit cluster.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_issue_ctrl_rr_arb2.sv | 26 ++
 rtl/alu_issue_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared definitions for the ALU issue controller:
//     - state_e      : controller state encoding (IDLE/ISSUE/WAIT/RESP)
//     - UNIT_*       : unit select values carried in fun[3:2]
//     - LOGIC_*      : op codes understood by the logic unit
//     - unit_onehot  : maps a unit select to its one-hot enable vector
//                      (bit 0 arith, 1 logic, 2 cmp, 3 shift)
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam logic [1:0] LOGIC_AND  = 2'b00;
  localparam logic [1:0] LOGIC_OR   = 2'b01;
  localparam logic [1:0] LOGIC_NAND = 2'b10;
  localparam logic [1:0] LOGIC_NOR  = 2'b11;

  function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
    unit_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant. A lone requester always wins; when both
//   request, the requester named by the priority pointer wins.
//   Ports:
//     req_i [1:0]  request vector (bit n = requester n)
//     ptr_i        priority pointer: requester that wins a tie
//     gnt_o [1:0]  one-hot (or zero) grant vector
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Schedules commands from two requesters onto a shared ALU unit cluster
//   (arith, logic, cmp, shift). One command is in flight at a time:
//   IDLE (accept) -> ISSUE (one enable pulse) -> WAIT (capture the unit's
//   registered result) -> RESP (hold response until consumed).
//
//   Configuration macro:
//     ALU_ISSUE_FIXED_PRIO_EN  defined   : requester 0 wins every tie, no
//                                          round-robin pointer
//                              undefined : round-robin via rr_arb2
//
//   Ports:
//     CLK, RST                    clock (rising edge), async active-low reset
//     reqN_valid/ready/a/b/fun    command channels, fun[3:2] unit, fun[1:0] op
//     unit_a, unit_b, unit_op     operands/op broadcast to all units
//     *_en                        unit enables, at most one high (ISSUE only)
//     *_out, *_flag               registered unit results and valid flags
//     rsp_valid/ready/data/id/err response channel; err = unit flag was low
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_fun,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic [1:0]       unit_op,
  output logic             arith_en,
  output logic             logic_en,
  output logic             cmp_en,
  output logic             shift_en,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  import alu_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic             run_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       fun_q, fun_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_id_q, rsp_id_d;

  logic [1:0]       req_valid;
  logic [1:0]       gnt;
  logic             hs;
  logic             hs_id;
  logic [3:0]       en_vec;
  logic [WIDTH-1:0] sel_out;
  logic             sel_flag;

  assign req_valid = {req1_valid, req0_valid};

`ifdef ALU_ISSUE_FIXED_PRIO_EN
  assign gnt = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`else
  logic rr_ptr_q, rr_ptr_d;

  rr_arb2 u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // The loser of this handshake gets priority on the next tie.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = ~hs_id;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rr_ptr_q <= 1'b0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`endif

  // run_q clears asynchronously with reset; without it the ready outputs
  // would follow valid while reset holds the state at IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  assign req0_ready = run_q & (state_q == IDLE) & gnt[0];
  assign req1_ready = run_q & (state_q == IDLE) & gnt[1];
  assign hs         = req0_ready | req1_ready;
  assign hs_id      = req1_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    en_vec    = 4'b0000;
    rsp_valid = 1'b0;
    if (state_q == ISSUE) en_vec = unit_onehot(fun_q[3:2]);
    if (state_q == RESP)  rsp_valid = 1'b1;
  end

  assign arith_en = en_vec[0];
  assign logic_en = en_vec[1];
  assign cmp_en   = en_vec[2];
  assign shift_en = en_vec[3];

  // ---------------- result select ----------------
  always_comb begin
    sel_out  = arith_out;
    sel_flag = arith_flag;
    case (fun_q[3:2])
      UNIT_LOGIC: begin sel_out = logic_out; sel_flag = logic_flag; end
      UNIT_CMP:   begin sel_out = cmp_out;   sel_flag = cmp_flag;   end
      UNIT_SHIFT: begin sel_out = shift_out; sel_flag = shift_flag; end
      default:    begin sel_out = arith_out; sel_flag = arith_flag; end
    endcase
  end

  // ---------------- operand / response registers ----------------
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_id_d   = rsp_id_q;
    if (hs) begin
      a_d   = hs_id ? req1_a   : req0_a;
      b_d   = hs_id ? req1_b   : req0_b;
      fun_d = hs_id ? req1_fun : req0_fun;
      id_d  = hs_id;
    end
    // Units register their result on the ISSUE edge, so it is valid in WAIT.
    if (state_q == WAIT) begin
      rsp_data_d = sel_out;
      rsp_err_d  = ~sel_flag;
      rsp_id_d   = id_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Operand registers drive the units directly, so the broadcast bus holds
  // its last value outside ISSUE.
  assign unit_a   = a_q;
  assign unit_b   = b_q;
  assign unit_op  = fun_q[1:0];
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_fun, req1_fun;
  logic [WIDTH-1:0] unit_a, unit_b;
  logic [1:0]       unit_op;
  logic             arith_en, logic_en, cmp_en, shift_en;
  logic [WIDTH-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic             arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic             cmp_flag_ok = 1'b1;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
    .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Unit cluster models: one-cycle registered result, flag = enable delayed.
  always @(posedge CLK) begin
    arith_flag <= arith_en;
    if (arith_en) arith_out <= (unit_op == 2'b01) ? unit_a - unit_b : unit_a + unit_b;
    logic_flag <= logic_en;
    if (logic_en) begin
      case (unit_op)
        2'b00:   logic_out <= unit_a & unit_b;
        2'b01:   logic_out <= unit_a | unit_b;
        2'b10:   logic_out <= ~(unit_a & unit_b);
        default: logic_out <= ~(unit_a | unit_b);
      endcase
    end
    cmp_flag <= cmp_en & cmp_flag_ok;
    if (cmp_en) cmp_out <= WIDTH'(unit_a < unit_b);
    shift_flag <= shift_en;
    if (shift_en) shift_out <= unit_a << unit_b[3:0];
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             id;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state
  int               rsp_count = 0;
  int               first_valid_cyc = -1;
  int               en_total = 0;
  int               en_cmp_cnt = 0;
  int               en_cyc = -1;
  logic [3:0]       en_vec_last = '0;
  logic [1:0]       en_op_last = '0;
  logic [WIDTH-1:0] en_a_last = '0, en_b_last = '0;

  // Response scoreboard / enable monitor, sampled on the falling edge.
  initial begin
    logic [3:0] ev;
    logic       prev_valid;
    exp_t       e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      ev = {shift_en, cmp_en, logic_en, arith_en};
      if (ev != 4'b0000) begin
        en_total++;
        if (cmp_en) en_cmp_cnt++;
        en_cyc      = cyc;
        en_vec_last = ev;
        en_op_last  = unit_op;
        en_a_last   = unit_a;
        en_b_last   = unit_b;
        chk("en_onehot", $countones(ev), 1);
      end
      if (rsp_valid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {15'b0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("RSP cycle=%0d id=%0d data=%h err=%0d (exp id=%0d data=%h err=%0d)",
                   cyc, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic send(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [3:0] fun, input logic [WIDTH-1:0] ed, input logic ee,
                      input bit keep, output int hs_c);
    int   n;
    logic rdy;
    exp_t e;
    if (r == 0) begin req0_a = a; req0_b = b; req0_fun = fun; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_fun = fun; req1_valid = 1'b1; end
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      rdy = (r == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 200);
    if (!rdy) begin
      chk("hs_timeout", 0, 1);
      hs_c = -1;
      if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      return;
    end
    e.data = ed; e.id = r[0]; e.err = ee;
    exp_q.push_back(e);
    grant_q.push_back(r);
    hs_c = cyc;
    $display("REQ%0d accepted cycle=%0d a=%h b=%h fun=%b", r, cyc, a, b, fun);
    @(posedge CLK);
    #1;
    if (!keep) begin
      if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0 || rsp_valid) chk("drain_timeout", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_unit_ab"}, {unit_a, unit_b}, 32'h0);
    chk({tag, "_rsp_data"}, {16'h0, rsp_data}, 32'h0);
    chk({tag, "_ctrl"}, {22'h0, req0_ready, req1_ready, unit_op, arith_en, logic_en,
                         cmp_en, shift_en, rsp_valid, rsp_id, rsp_err}, 32'h0);
  endtask

  initial begin
    int h1, h2, hx0, hx1, hy0, hy1, c0, n;
    int exp_grants[4];
    RST = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fun = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fun = '0;

    // Reset state, with a requester already valid
    req0_valid = 1'b1; req0_a = 16'hAAAA;
    #12;
    chk_all_zero("reset");
    req0_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;

    // Single logic AND command: latency and unit sequencing
    c0 = en_total;
    send(0, 16'h00FF, 16'h0F0F, 4'b0100, 16'h000F, 1'b0, 1'b0, h1);
    drain();
    chk("t1_en_count", en_total - c0, 1);
    chk("t1_en_lat", en_cyc - h1, 1);
    chk("t1_en_vec", en_vec_last, 4'b0010);
    chk("t1_unit_op", en_op_last, 0);
    chk("t1_unit_ab", {en_a_last, en_b_last}, 32'h00FF_0F0F);
    chk("t1_rsp_lat", first_valid_cyc - h1, 3);

    // Backpressure: response held 5 cycles, no new command accepted
    rsp_ready = 1'b0;
    send(0, 16'h1111, 16'h2222, 4'b0000, 16'h3333, 1'b0, 1'b0, h1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge CLK); n++; end
    chk("bp_rsp_seen", rsp_valid, 1);
    req1_a = 16'h0001; req1_b = 16'h0004; req1_fun = 4'b1100; req1_valid = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'h3333);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge CLK); #1;
    c0 = rsp_count;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_done", rsp_count - c0, 1);
    chk("bp_valid_drop", rsp_valid, 0);
    send(1, 16'h0001, 16'h0004, 4'b1100, 16'h0010, 1'b0, 1'b0, h1);
    drain();

    // Compare with unit flag forced low -> error response
    cmp_flag_ok = 1'b0;
    c0 = en_cmp_cnt;
    send(0, 16'h0003, 16'h0005, 4'b1000, 16'h0001, 1'b1, 1'b0, h1);
    drain();
    chk("cmp_en_pulses", en_cmp_cnt - c0, 1);
    cmp_flag_ok = 1'b1;

    // Back-to-back NAND then NOR
    send(0, 16'hFFFF, 16'hFFFF, 4'b0110, 16'h0000, 1'b0, 1'b1, h1);
    send(0, 16'hFFFF, 16'hFFFF, 4'b0111, 16'h0000, 1'b0, 1'b0, h2);
    chk("b2b_spacing", (h2 - h1 >= 4) ? 1 : 0, 1);
    drain();

    // Reset asserted while the command is in WAIT
    send(0, 16'hBEEF, 16'h1234, 4'b0001, 16'h0000, 1'b0, 1'b0, h1);
    @(posedge CLK); #1;
    RST = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk_all_zero("midrst");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    c0 = rsp_count;
    repeat (6) @(posedge CLK);
    #1;
    chk("no_rsp_after_rst", rsp_count - c0, 0);

    // Both requesters valid continuously (pointer starts at 0 after reset)
    grant_q.delete();
    fork
      begin
        send(0, 16'h1200, 16'h0034, 4'b0101, 16'h1234, 1'b0, 1'b1, hx0);
        send(0, 16'h0500, 16'h0006, 4'b0101, 16'h0506, 1'b0, 1'b0, hx1);
      end
      begin
        send(1, 16'hA000, 16'h0B0C, 4'b0101, 16'hAB0C, 1'b0, 1'b1, hy0);
        send(1, 16'h00C0, 16'h0D00, 4'b0101, 16'h0DC0, 1'b0, 1'b0, hy1);
      end
    join
    drain();
`ifdef ALU_ISSUE_FIXED_PRIO_EN
    exp_grants = '{0, 0, 1, 1};
`else
    exp_grants = '{0, 1, 0, 1};
`endif
    chk("grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_q.size()) chk("grant_order", grant_q[i], exp_grants[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
